dm_access_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency data memory between two requesters: port 0 = pipeline MEM stage, port 1 = debug/DMA.

---
 rtl/dm_access_arbiter_if.sv | 33 +++
 rtl/dm_access_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dm_access_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_arbiter_if.sv
// Requester, response and memory-side signals of the data-memory arbiter.
// slave = the arbiter itself; master = requesters plus the memory.
interface dm_access_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic [1:0]             rq_valid;
   logic [1:0]             rq_we;
   logic [1:0][1:0]        rq_size;
   logic [1:0][ADDR_W-1:0] rq_addr;
   logic [1:0][31:0]       rq_wdata;
   logic [1:0]             rq_ready;
   logic [1:0]             rs_valid;
   logic                   rs_err;
   logic [31:0]            rs_rdata;
   logic [1:0]             rs_low2;
   logic                   mem_en;
   logic [3:0]             mem_be;
   logic [ADDR_W-3:0]      mem_addr;
   logic [31:0]            mem_wdata;
   logic [31:0]            mem_rdata;

   modport slave (
      input  rq_valid, rq_we, rq_size, rq_addr, rq_wdata, mem_rdata,
      output rq_ready, rs_valid, rs_err, rs_rdata, rs_low2,
             mem_en, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output rq_valid, rq_we, rq_size, rq_addr, rq_wdata, mem_rdata,
      input  rq_ready, rs_valid, rs_err, rs_rdata, rs_low2,
             mem_en, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dm_access_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data memory between the
// pipeline MEM stage (port 0) and debug/DMA (port 1), one access in flight.
module dm_access_arbiter #(
   parameter int LAT    = 2,
   parameter int ADDR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   dm_access_arbiter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ERR} state_e;

   localparam logic [3:0] LAT_C = 4'(LAT);

   state_e            state_q, state_d;
   logic              rr_q, rr_d;
   logic              id_q, id_d;
   logic              we_q, we_d;
   logic [1:0]        low2_q, low2_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              mem_en_q, mem_en_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;

   logic [1:0]        grant;
   logic              sel;
   logic [1:0]        rs_valid;
   logic              rs_err;
   logic [31:0]       rs_rdata;
   logic [1:0]        rs_low2;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] low2);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return low2[0];
         2'b10:   return |low2;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] low2);
      case (size)
         2'b00:   return 4'b0001 << low2;
         2'b01:   return 4'b0011 << low2;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      id_d        = id_q;
      we_d        = we_q;
      low2_d      = low2_q;
      rdata_d     = rdata_q;
      cnt_d       = cnt_q;
      mem_en_d    = 1'b0;
      mem_be_d    = 4'b0000;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      grant       = 2'b00;
      sel         = 1'b0;
      rs_valid    = 2'b00;
      rs_err      = 1'b0;
      rs_rdata    = '0;
      rs_low2     = 2'b00;

      case (state_q)
         S_IDLE: begin
            case (bus.rq_valid)
               2'b01:   grant = 2'b01;
               2'b10:   grant = 2'b10;
               2'b11: begin
                  grant = rr_q ? 2'b10 : 2'b01;
                  rr_d  = ~rr_q;
               end
               default: grant = 2'b00;
            endcase
            sel = grant[1];
            if (|grant) begin
               id_d    = sel;
               we_d    = bus.rq_we[sel];
               low2_d  = bus.rq_addr[sel][1:0];
               rdata_d = '0;
               cnt_d   = 4'd0;
               if (misaligned(bus.rq_size[sel], bus.rq_addr[sel][1:0])) begin
                  state_d = S_ERR;
               end else begin
                  state_d     = S_WAIT;
                  mem_en_d    = 1'b1;
                  mem_be_d    = bus.rq_we[sel] ? lane_be(bus.rq_size[sel], bus.rq_addr[sel][1:0]) : 4'b0000;
                  mem_addr_d  = bus.rq_addr[sel][ADDR_W-1:2];
                  mem_wdata_d = bus.rq_we[sel] ? lane_data(bus.rq_size[sel], bus.rq_wdata[sel]) : 32'd0;
               end
            end
         end
         // cnt_q == 0 marks the mem_en cycle; read data lands LAT cycles later
         S_WAIT: begin
            if (cnt_q == LAT_C) begin
               rdata_d = bus.mem_rdata;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RESP: begin
            rs_valid[id_q] = 1'b1;
            rs_rdata       = we_q ? 32'd0 : rdata_q;
            rs_low2        = low2_q;
            state_d        = S_IDLE;
         end
         // error response is held one cycle so it occupies the same slot as a registered issue
         S_ERR: begin
            if (cnt_q == 4'd0) begin
               cnt_d = 4'd1;
            end else begin
               rs_valid[id_q] = 1'b1;
               rs_err         = 1'b1;
               rs_low2        = low2_q;
               state_d        = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rr_q        <= 1'b0;
         id_q        <= 1'b0;
         we_q        <= 1'b0;
         low2_q      <= 2'b00;
         rdata_q     <= '0;
         cnt_q       <= 4'd0;
         mem_en_q    <= 1'b0;
         mem_be_q    <= 4'b0000;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         id_q        <= id_d;
         we_q        <= we_d;
         low2_q      <= low2_d;
         rdata_q     <= rdata_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // ready is masked while reset is held so every output reads 0 during reset
   assign bus.rq_ready  = grant & {2{reset}};
   assign bus.rs_valid  = rs_valid;
   assign bus.rs_err    = rs_err;
   assign bus.rs_rdata  = rs_rdata;
   assign bus.rs_low2   = rs_low2;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: directed and random requests checked against a
// transaction-level model of arbitration, lane mapping, latency and a memory array.
module tb_dm_access_arbiter;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dm_access_arbiter_if #(.ADDR_W(32)) bus ();
   dm_access_arbiter #(.LAT(LAT), .ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [31:0] mem [64];
   int          rd_due = -1;
   logic [31:0] rd_word;

   int          en_cyc = -1;
   int          rs_cyc = -1;
   int          e_port;
   logic        e_we, e_err;
   logic [3:0]  e_be;
   logic [31:0] e_maddr, e_wd, e_rdata;
   logic [1:0]  e_low2;

   logic        pw [2];
   logic [1:0]  ps [2];
   logic [31:0] pa [2];
   logic [31:0] pd [2];
   int          rr = 0;
   logic [1:0]  last_ready;
   logic [1:0]  grants [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.mem_en === 1'b1) begin
         if (bus.mem_be != 4'b0000) begin
            for (int i = 0; i < 4; i++)
               if (bus.mem_be[i]) mem[bus.mem_addr[5:0]][8*i +: 8] = bus.mem_wdata[8*i +: 8];
         end else begin
            rd_due  = cyc + LAT;
            rd_word = mem[bus.mem_addr[5:0]];
         end
      end
      bus.mem_rdata = (cyc == rd_due) ? rd_word : $urandom();
      if (cyc == en_cyc) begin
         chk("mem_en", bus.mem_en, 1);
         chk("mem_be", bus.mem_be, e_be);
         chk("mem_addr", bus.mem_addr, e_maddr);
         if (e_we) chk("mem_wdata", bus.mem_wdata, e_wd);
      end else begin
         chk("mem_en_quiet", bus.mem_en, 0);
      end
      if (cyc == rs_cyc) begin
         chk("rs_valid", bus.rs_valid, 32'(1 << e_port));
         chk("rs_err", bus.rs_err, e_err);
         chk("rs_rdata", bus.rs_rdata, e_rdata);
         chk("rs_low2", bus.rs_low2, e_low2);
      end else begin
         chk("rs_quiet", {bus.rs_valid, bus.rs_err, bus.rs_low2}, 0);
         chk("rs_rdata_quiet", bus.rs_rdata, 0);
      end
   endtask

   task automatic load(input int p, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
      pw[p] = we; ps[p] = sz; pa[p] = a; pd[p] = d;
      bus.rq_we[p]    = we;
      bus.rq_size[p]  = sz;
      bus.rq_addr[p]  = a;
      bus.rq_wdata[p] = d;
      bus.rq_valid[p] = 1'b1;
   endtask

   task automatic load_rand(input int p);
      load(p, 1'($urandom), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 255)), $urandom());
   endtask

   // Expected consequences of accepting port p in the current cycle.
   task automatic expect_txn(input int p);
      int          n;
      logic [31:0] a;
      n      = 1 << ps[p];
      a      = pa[p];
      e_port = p;
      e_we   = pw[p];
      e_low2 = a[1:0];
      e_err  = (ps[p] == 2'd3) || ((a % n) != 0);
      if (e_err) begin
         en_cyc  = -1;
         rs_cyc  = cyc + 2;
         e_rdata = 32'd0;
      end else begin
         en_cyc  = cyc + 1;
         rs_cyc  = cyc + LAT + 2;
         e_maddr = a >> 2;
         e_be    = pw[p] ? 4'(((1 << n) - 1) << a[1:0]) : 4'b0000;
         for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = pd[p][8*(i % n) +: 8];
         e_rdata = pw[p] ? 32'd0 : mem[e_maddr[5:0]];
      end
   endtask

   task automatic accept(input bit reload, output int p);
      int         budget;
      logic [1:0] v, g;
      budget = 0;
      p = -1;
      while (p < 0) begin
         #1;
         v = bus.rq_valid;
         if (cyc <= rs_cyc)   g = 2'b00;
         else if (v == 2'b11) g = (rr == 1) ? 2'b10 : 2'b01;
         else                 g = v;
         chk("rq_ready", bus.rq_ready, g);
         if (g != 2'b00) begin
            last_ready = bus.rq_ready;
            p = g[1] ? 1 : 0;
            if (v == 2'b11) rr = 1 - rr;
            expect_txn(p);
            tick();
            if (reload) load_rand(p);
            else bus.rq_valid[p] = 1'b0;
         end else begin
            tick();
            budget++;
            if (budget > 100) begin
               chk("accept_timeout", 32'(budget), 0);
               p = 0;
            end
         end
      end
   endtask

   task automatic drain();
      while (cyc <= rs_cyc) tick();
   endtask

   initial begin
      int p;
      reset         = 1'b0;
      bus.rq_valid  = 2'b00;
      bus.rq_we     = 2'b00;
      bus.rq_size   = '0;
      bus.rq_addr   = '0;
      bus.rq_wdata  = '0;
      bus.mem_rdata = 32'd0;
      for (int i = 0; i < 64; i++) mem[i] = $urandom();

      repeat (2) tick();
      bus.rq_valid = 2'b11;
      #1;
      chk("reset_ready", bus.rq_ready, 0);
      chk("reset_mem_be", bus.mem_be, 0);
      chk("reset_mem_addr", bus.mem_addr, 0);
      chk("reset_mem_wdata", bus.mem_wdata, 0);
      bus.rq_valid = 2'b00;
      reset = 1'b1;
      tick();

      mem[4] = 32'hDEADBEEF;
      load(0, 1'b0, 2'b10, 32'h10, 32'h0);
      accept(0, p); drain();
      load(1, 1'b1, 2'b00, 32'h13, 32'hA5);
      accept(0, p); drain();
      load(0, 1'b0, 2'b01, 32'h21, 32'h0);
      accept(0, p); drain();
      load(0, 1'b0, 2'b11, 32'h0, 32'h0);
      accept(0, p); drain();
      load(0, 1'b1, 2'b01, 32'h2, 32'h1234);
      accept(0, p); drain();
      load(0, 1'b0, 2'b10, 32'h10, 32'h0);
      accept(0, p); drain();

      load(0, 1'b0, 2'b10, 32'h40, 32'h0);
      load(1, 1'b1, 2'b10, 32'h44, $urandom());
      grants.delete();
      repeat (4) begin
         accept(1, p);
         grants.push_back(last_ready);
      end
      bus.rq_valid = 2'b00;
      drain();
      for (int i = 0; i < 4; i++) chk("rr_order", grants[i], 32'(1 << (i % 2)));

      load(0, 1'b0, 2'b10, 32'h80, 32'h0);
      accept(0, p);
      load(1, 1'b1, 2'b10, 32'h84, 32'h5555AAAA);
      tick();
      bus.rq_valid[1] = 1'b0;
      drain();

      load(0, 1'b0, 2'b10, 32'h8, 32'h0);
      accept(0, p);
      #1 reset = 1'b0;
      #1;
      chk("abort_mem_en", bus.mem_en, 0);
      chk("abort_rs_valid", bus.rs_valid, 0);
      chk("abort_ready", bus.rq_ready, 0);
      en_cyc = -1; rs_cyc = -1; rd_due = -1; rr = 0;
      repeat (2) tick();
      reset = 1'b1;
      repeat (6) tick();
      load(0, 1'b0, 2'b10, 32'h8, 32'h0);
      accept(0, p); drain();

      repeat (40) begin
         case ($urandom_range(0, 2))
            0:       load_rand(0);
            1:       load_rand(1);
            default: begin load_rand(0); load_rand(1); end
         endcase
         accept(0, p);
         bus.rq_valid = 2'b00;
         if ($urandom_range(0, 1) == 1) drain();
      end
      drain();
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
